// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

  typedef enum logic [2:0] {
    GAP,
    REQ,
    WAIT,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter; bit_done marks the last cycle of each bit
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int                CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] baudCnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      baudCnt <= '0;
    end else if (baudCnt == LAST) begin
      baudCnt <= '0;
    end else begin
      baudCnt <= baudCnt + 1'b1;
    end
  end

  assign bit_done = !clear && (baudCnt == LAST);

endmodule

// File: rtl/uart_tx_stage.sv
// rtl/uart_tx_stage.sv - pulls bytes from the ring buffer and sends 8N1 frames on txOut
// Optional even-parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_stage
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int RETRY_GAP    = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       dataReadEnable,
  input  logic       dataReadAck,
  input  logic [7:0] dataRead,
  output logic       txOut,
  output logic       busy
);

  localparam int               GAP_W    = $clog2(RETRY_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RETRY_GAP - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_t        state, stateNext;
  logic [GAP_W-1:0] gapCnt, gapCntNext;
  logic [2:0]       bitIdx, bitIdxNext;
  logic [7:0]       shiftReg, shiftNext;
  logic             txNext;
  logic             bitDone;
  logic             baudClear;
`ifdef UART_TX_PARITY_EN
  logic             parityBit, parityNext;
`endif

  // Baud counter is held clear outside a frame so START always gets a full bit period.
  assign baudClear = (state == GAP) || (state == REQ) || (state == WAIT);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) baudTick (
    .clk      (clk),
    .reset    (reset),
    .clear    (baudClear),
    .bit_done (bitDone)
  );

  always_comb begin
    stateNext  = state;
    gapCntNext = gapCnt;
    bitIdxNext = bitIdx;
    shiftNext  = shiftReg;
`ifdef UART_TX_PARITY_EN
    parityNext = parityBit;
`endif
    case (state)
      GAP: begin
        if (gapCnt == GAP_LAST) begin
          stateNext  = REQ;
          gapCntNext = '0;
        end else begin
          gapCntNext = gapCnt + 1'b1;
        end
      end
      REQ: stateNext = WAIT;
      WAIT: begin
        if (dataReadAck) begin
          stateNext  = START;
          shiftNext  = dataRead;
          bitIdxNext = '0;
`ifdef UART_TX_PARITY_EN
          parityNext = ^dataRead;
`endif
        end else begin
          stateNext = GAP;
        end
      end
      START: if (bitDone) stateNext = DATA;
      DATA: begin
        if (bitDone) begin
          shiftNext  = shiftReg >> 1;
          bitIdxNext = bitIdx + 1'b1;
          if (bitIdx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            stateNext = PAR;
`else
            stateNext = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PAR: if (bitDone) stateNext = STOP;
`endif
      // Straight back to REQ so a non-empty buffer drains with only REQ+WAIT between frames.
      STOP: if (bitDone) stateNext = REQ;
      default: stateNext = GAP;
    endcase

    txNext = UART_IDLE_LEVEL;
    case (stateNext)
      START: txNext = 1'b0;
      DATA:  txNext = shiftNext[0];
`ifdef UART_TX_PARITY_EN
      PAR:   txNext = parityNext;
`endif
      default: txNext = UART_IDLE_LEVEL;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= GAP;
      gapCnt         <= '0;
      bitIdx         <= '0;
      shiftReg       <= '0;
      dataReadEnable <= 1'b0;
      txOut          <= UART_IDLE_LEVEL;
      busy           <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parityBit      <= 1'b0;
`endif
    end else begin
      state          <= stateNext;
      gapCnt         <= gapCntNext;
      bitIdx         <= bitIdxNext;
      shiftReg       <= shiftNext;
      dataReadEnable <= (stateNext == REQ);
      txOut          <= txNext;
      busy           <= (stateNext == START) || (stateNext == DATA) ||
                        (stateNext == PAR)   || (stateNext == STOP);
`ifdef UART_TX_PARITY_EN
      parityBit      <= parityNext;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_stage.sv
// tb/tb_uart_tx_stage.sv - directed self-checking bench for uart_tx_stage
module tb_uart_tx_stage;

  localparam int CPB  = 4;
  localparam int RGAP = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dataReadEnable;
  logic       dataReadAck;
  logic [7:0] dataRead;
  logic       txOut;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [8:0] respQ[$];
  logic       txCap[0:63];
  logic       busyCap[0:63];
  logic       expTx[0:63];

  always #5 clk = ~clk;

  uart_tx_stage #(.CLKS_PER_BIT(CPB), .RETRY_GAP(RGAP)) dut (
    .clk            (clk),
    .reset          (reset),
    .dataReadEnable (dataReadEnable),
    .dataReadAck    (dataReadAck),
    .dataRead       (dataRead),
    .txOut          (txOut),
    .busy           (busy)
  );

  // Buffer: registered response one cycle after a request; ack level is held otherwise.
  always @(posedge clk) begin
    if (reset) begin
      dataReadAck <= 1'b0;
      dataRead    <= 8'h00;
    end else if (dataReadEnable) begin
      if (respQ.size() > 0) begin
        dataReadAck <= respQ[0][8];
        dataRead    <= respQ[0][7:0];
        respQ.delete(0);
      end else begin
        dataReadAck <= 1'b0;
      end
    end
  end

  task automatic waitReq(output int n, output bit ok, output bit allIdle);
    n = 0; ok = 1'b0; allIdle = 1'b1;
    while (n < 50 && !ok) begin
      @(negedge clk);
      n++;
      if (txOut !== 1'b1 || busy !== 1'b0) allIdle = 1'b0;
      if (dataReadEnable === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      txCap[i]   = txOut;
      busyCap[i] = busy;
    end
  endtask

  function automatic void buildFrame(input logic [7:0] d);
    for (int i = 0; i < FRAME_CYC; i++) begin
      int pos;
      pos = i / CPB;
      if (pos == 0)                          expTx[i] = 1'b0;
      else if (pos <= 8)                     expTx[i] = d[pos-1];
      else if (pos == 9 && FRAME_BITS == 11) expTx[i] = ^d;
      else                                   expTx[i] = 1'b1;
    end
  endfunction

  task automatic test_reset();
    int n; bit ok, idle;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (txOut !== 1'b1) begin errors++; $display("FAIL reset_txOut got=%b exp=1", txOut); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (dataReadEnable !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", dataReadEnable); end
    reset = 1'b0;
    waitReq(n, ok, idle);
    checks++; if (!ok || n != RGAP || !idle) begin errors++; $display("FAIL reset_first_req ok=%b cycles=%0d idle=%b exp cycles=%0d idle=1", ok, n, idle, RGAP); end
    @(negedge clk);
  endtask

  task automatic test_empty();
    int n; bit ok, idle;
    for (int r = 0; r < 3; r++) begin
      waitReq(n, ok, idle);
      checks++;
      if (!ok || n != ((r == 0) ? RGAP + 1 : RGAP + 2) || !idle) begin
        errors++;
        $display("FAIL empty_poll round=%0d ok=%b cycles=%0d idle=%b exp cycles=%0d idle=1", r, ok, n, idle, (r == 0) ? RGAP + 1 : RGAP + 2);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    int n; bit ok, idle;
    respQ.push_back({1'b1, 8'h55});
    waitReq(n, ok, idle);
    checks++; if (!ok) begin errors++; $display("FAIL single_req got=timeout exp=request"); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || txOut !== 1'b1) begin errors++; $display("FAIL single_wait busy=%b tx=%b exp busy=0 tx=1", busy, txOut); end
    buildFrame(8'h55);
    capture(FRAME_CYC);
    for (int i = 0; i < FRAME_CYC; i++) begin
      checks++;
      if (txCap[i] !== expTx[i] || busyCap[i] !== 1'b1) begin
        errors++; $display("FAIL single_frame cycle=%0d tx=%b busy=%b exp tx=%b busy=1", i, txCap[i], busyCap[i], expTx[i]);
      end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || dataReadEnable !== 1'b1) begin errors++; $display("FAIL single_next_req busy=%b req=%b exp busy=0 req=1", busy, dataReadEnable); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n; bit ok, idle;
    respQ.push_back({1'b1, 8'hA3});
    respQ.push_back({1'b1, 8'h0F});
    waitReq(n, ok, idle);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_req got=timeout exp=request"); end
    @(negedge clk);
    buildFrame(8'hA3);
    capture(FRAME_CYC);
    for (int i = 0; i < FRAME_CYC; i++) begin
      checks++;
      if (txCap[i] !== expTx[i] || busyCap[i] !== 1'b1) begin
        errors++; $display("FAIL b2b_frame1 cycle=%0d tx=%b busy=%b exp tx=%b busy=1", i, txCap[i], busyCap[i], expTx[i]);
      end
    end
    @(negedge clk);
    checks++; if (txOut !== 1'b1 || busy !== 1'b0 || dataReadEnable !== 1'b1) begin errors++; $display("FAIL b2b_idle1 tx=%b busy=%b req=%b exp 1 0 1", txOut, busy, dataReadEnable); end
    @(negedge clk);
    checks++; if (txOut !== 1'b1 || busy !== 1'b0 || dataReadEnable !== 1'b0) begin errors++; $display("FAIL b2b_idle2 tx=%b busy=%b req=%b exp 1 0 0", txOut, busy, dataReadEnable); end
    buildFrame(8'h0F);
    capture(FRAME_CYC);
    for (int i = 0; i < FRAME_CYC; i++) begin
      checks++;
      if (txCap[i] !== expTx[i] || busyCap[i] !== 1'b1) begin
        errors++; $display("FAIL b2b_frame2 cycle=%0d tx=%b busy=%b exp tx=%b busy=1", i, txCap[i], busyCap[i], expTx[i]);
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_rejected();
    int n; bit ok, idle;
    respQ.push_back({1'b0, 8'h00});
    respQ.push_back({1'b1, 8'h7E});
    waitReq(n, ok, idle);
    checks++; if (!ok) begin errors++; $display("FAIL reject_first_req got=timeout exp=request"); end
    waitReq(n, ok, idle);
    checks++; if (!ok || n != RGAP + 2 || !idle) begin errors++; $display("FAIL reject_retry ok=%b cycles=%0d idle=%b exp cycles=%0d idle=1", ok, n, idle, RGAP + 2); end
    @(negedge clk);
    buildFrame(8'h7E);
    capture(FRAME_CYC);
    for (int i = 0; i < FRAME_CYC; i++) begin
      checks++;
      if (txCap[i] !== expTx[i] || busyCap[i] !== 1'b1) begin
        errors++; $display("FAIL reject_frame cycle=%0d tx=%b busy=%b exp tx=%b busy=1", i, txCap[i], busyCap[i], expTx[i]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    waitReq(n, ok, idle);
    checks++; if (!ok || n != RGAP + 1 || !idle) begin errors++; $display("FAIL reject_no_duplicate ok=%b cycles=%0d idle=%b exp cycles=%0d idle=1", ok, n, idle, RGAP + 1); end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    int n; bit ok, idle;
    respQ.push_back({1'b1, 8'hFF});
    waitReq(n, ok, idle);
    checks++; if (!ok) begin errors++; $display("FAIL midreset_req got=timeout exp=request"); end
    @(negedge clk);
    repeat (18) @(negedge clk);
    checks++; if (busy !== 1'b1 || txOut !== 1'b1) begin errors++; $display("FAIL midreset_bit3 busy=%b tx=%b exp busy=1 tx=1", busy, txOut); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (txOut !== 1'b1 || busy !== 1'b0 || dataReadEnable !== 1'b0) begin errors++; $display("FAIL midreset_abort tx=%b busy=%b req=%b exp 1 0 0", txOut, busy, dataReadEnable); end
    reset = 1'b0;
    waitReq(n, ok, idle);
    checks++; if (!ok || n != RGAP || !idle) begin errors++; $display("FAIL midreset_first_req ok=%b cycles=%0d idle=%b exp cycles=%0d idle=1", ok, n, idle, RGAP); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_no_reread busy=%b exp 0", busy); end
  endtask

  task automatic test_parity();
    int n; bit ok, idle;
    respQ.push_back({1'b1, 8'h07});
    waitReq(n, ok, idle);
    checks++; if (!ok) begin errors++; $display("FAIL parity_req got=timeout exp=request"); end
    @(negedge clk);
    buildFrame(8'h07);
    capture(FRAME_CYC);
    for (int i = 0; i < FRAME_CYC; i++) begin
      checks++;
      if (txCap[i] !== expTx[i] || busyCap[i] !== 1'b1) begin
        errors++; $display("FAIL parity_frame cycle=%0d tx=%b busy=%b exp tx=%b busy=1", i, txCap[i], busyCap[i], expTx[i]);
      end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || dataReadEnable !== 1'b1) begin errors++; $display("FAIL parity_frame_len busy=%b req=%b exp busy=0 req=1 after %0d cycles", busy, dataReadEnable, FRAME_CYC); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_back_to_back();
    test_rejected();
    test_reset_midframe();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
